div_seq_ctrl: RTL and testbench



---
 rtl/div_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_div_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU.
// Holds no adder of its own. Every cycle it steers the shared 32-bit add/sub
// unit (as_sel/as_in0/as_in1) and registers the returned as_s/as_cout.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start_valid/ready      request handshake (ready only in IDLE)
//   op                     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   operand_a/b            dividend / divisor
//   flush                  abandon any in-flight operation
//   result_valid/ready     held-result handshake
//   result                 quotient or remainder
//   as_sel/in0/in1         to add/sub unit (sel 1 = in0 - in1)
//   as_s/as_cout           from add/sub unit (cout 1 = no borrow on sub)
module div_seq_ctrl #(
  parameter int unsigned FAST_SPECIAL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result,
  output logic        as_sel,
  output logic [31:0] as_in0,
  output logic [31:0] as_in1,
  input  logic [31:0] as_s,
  input  logic        as_cout
);

  typedef enum logic [2:0] {IDLE, FIXA, FIXB, ITER, FIXR, DONE} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q;
  logic        neg_a, neg_b, neg_q, spec_q;
  logic [31:0] dvd, dvs, rem;
  logic [4:0]  cnt;

  // request decode (op[0] = 0 means signed)
  logic        in_sgn, in_na, in_nb, in_bz, in_ovf, in_spec;
  assign in_sgn  = ~op[0];
  assign in_na   = in_sgn & operand_a[31];
  assign in_nb   = in_sgn & operand_b[31];
  assign in_bz   = (operand_b == 32'd0);
  assign in_ovf  = in_sgn & (operand_a == 32'h8000_0000) & (operand_b == 32'hFFFF_FFFF);
  assign in_spec = (FAST_SPECIAL != 0) & (in_bz | in_ovf);

  // special results from the latched request; b == 0 takes priority
  logic [31:0] spec_val;
  always_comb begin
    if (req_q.b == 32'd0) spec_val = req_q.op[1] ? req_q.a : 32'hFFFF_FFFF;
    else                  spec_val = req_q.op[1] ? 32'd0   : 32'h8000_0000;
  end

  // one restoring step: 33-bit partial remainder is {msb_out, shifted}
  logic [31:0] shifted;
  logic        msb_out, take;
  assign shifted = {rem[30:0], dvd[31]};
  assign msb_out = rem[31];
  assign take    = as_cout | msb_out;

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    as_sel    = 1'b0;
    as_in0    = 32'd0;
    as_in1    = 32'd0;
    case (state)
      IDLE: if (start_valid) state_nxt = in_spec ? FIXR : FIXA;
      FIXA: begin
        as_in1    = req_q.a;
        as_sel    = neg_a;
        state_nxt = FIXB;
      end
      FIXB: begin
        as_in1    = req_q.b;
        as_sel    = neg_b;
        state_nxt = ITER;
      end
      ITER: begin
        as_sel = 1'b1;
        as_in0 = shifted;
        as_in1 = dvs;
        if (cnt == 5'd31) state_nxt = FIXR;
      end
      FIXR: begin
        // special results spend this single slot without using the adder,
        // so both paths leave through the same FIXR -> DONE boundary
        if (!spec_q) begin
          as_in1 = req_q.op[1] ? rem   : dvd;
          as_sel = req_q.op[1] ? neg_a : neg_q;
        end
        state_nxt = DONE;
      end
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush && (state != IDLE)) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      neg_q  <= 1'b0;
      spec_q <= 1'b0;
      dvd    <= 32'd0;
      dvs    <= 32'd0;
      rem    <= 32'd0;
      cnt    <= 5'd0;
      result <= 32'd0;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          req_q  <= '{op: op, a: operand_a, b: operand_b};
          neg_a  <= in_na;
          neg_b  <= in_nb;
          neg_q  <= (in_na ^ in_nb) & ~in_bz;
          spec_q <= in_spec;
        end
        FIXA: dvd <= as_s;
        FIXB: begin
          dvs <= as_s;
          rem <= 32'd0;
          cnt <= 5'd0;
        end
        ITER: begin
          rem <= take ? as_s : shifted;
          dvd <= {dvd[30:0], take};
          cnt <= cnt + 5'd1;
        end
        FIXR: if (!flush) result <= spec_q ? spec_val : as_s;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: FAST_SPECIAL = 1, index 1: FAST_SPECIAL = 0
  logic        sv [2];
  logic        sr [2];
  logic [1:0]  opv [2];
  logic [31:0] av [2];
  logic [31:0] bv [2];
  logic        fl [2];
  logic        rv [2];
  logic        rr [2];
  logic [31:0] res [2];
  logic        asel [2];
  logic [31:0] ain0 [2];
  logic [31:0] ain1 [2];
  logic [31:0] as_s [2];
  logic        acout [2];

  div_seq_ctrl #(.FAST_SPECIAL(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[0]), .start_ready(sr[0]),
    .op(opv[0]), .operand_a(av[0]), .operand_b(bv[0]), .flush(fl[0]),
    .result_valid(rv[0]), .result_ready(rr[0]), .result(res[0]),
    .as_sel(asel[0]), .as_in0(ain0[0]), .as_in1(ain1[0]),
    .as_s(as_s[0]), .as_cout(acout[0]));

  div_seq_ctrl #(.FAST_SPECIAL(0)) u_full (
    .clk(clk), .rst_n(rst_n), .start_valid(sv[1]), .start_ready(sr[1]),
    .op(opv[1]), .operand_a(av[1]), .operand_b(bv[1]), .flush(fl[1]),
    .result_valid(rv[1]), .result_ready(rr[1]), .result(res[1]),
    .as_sel(asel[1]), .as_in0(ain0[1]), .as_in1(ain1[1]),
    .as_s(as_s[1]), .as_cout(acout[1]));

  // external ripple add/sub unit model, one per DUT
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (asel[i]) {acout[i], as_s[i]} = {1'b0, ain0[i]} + {1'b0, ~ain1[i]} + 33'd1;
      else         {acout[i], as_s[i]} = {1'b0, ain0[i]} + {1'b0, ain1[i]};
    end
  end

  int checks = 0;
  int failures = 0;
  logic [31:0] expq0 [$];
  logic [31:0] expq1 [$];

  // RISC-V M-extension semantics straight from the ISA rules
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      sa = int'(a);
      sb = int'(b);
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // scoreboard monitor: compare whenever a result is handed over
  always @(negedge clk) begin
    logic [31:0] e;
    bit have;
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (rv[i] && rr[i] && !fl[i]) begin
          have = 1'b0;
          e = 32'd0;
          if (i == 0) begin
            if (expq0.size() > 0) begin e = expq0.pop_front(); have = 1'b1; end
          end else begin
            if (expq1.size() > 0) begin e = expq1.pop_front(); have = 1'b1; end
          end
          checks++;
          if (!have) begin
            failures++;
            $display("FAIL result_unexpected inst=%0d got=%h (no pending request)", i, res[i]);
          end else if (res[i] !== e) begin
            failures++;
            $display("FAIL result inst=%0d got=%h want=%h", i, res[i], e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input bit ok, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic run_op(input int inst, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int lat, exp_lat;
    logic [31:0] held;
    bit ok;
    @(posedge clk); #1;
    opv[inst] = o; av[inst] = a; bv[inst] = b; sv[inst] = 1'b1;
    chk("start_ready_idle", sr[inst] === 1'b1, 32'(sr[inst]), 32'd1);
    if (inst == 0) expq0.push_back(ref_res(o, a, b));
    else           expq1.push_back(ref_res(o, a, b));
    exp_lat = (inst == 0 && is_special(o, a, b)) ? 1 : 35;
    @(posedge clk); #1;
    sv[inst] = 1'b0;
    lat = 0;
    while (rv[inst] !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat == exp_lat, 32'(lat), 32'(exp_lat));
    held = res[inst];
    for (int h = 0; h < hold; h++) begin
      opv[inst] = 2'($urandom_range(0, 3)); av[inst] = $urandom; bv[inst] = $urandom;
      sv[inst] = 1'b1;
      @(posedge clk); #1;
      ok = (rv[inst] === 1'b1) && (res[inst] === held) && (sr[inst] === 1'b0) &&
           (asel[inst] === 1'b0) && (ain0[inst] === 32'd0) && (ain1[inst] === 32'd0);
      chk("hold_stable", ok, res[inst], held);
    end
    sv[inst] = 1'b0;
    rr[inst] = 1'b1;
    @(posedge clk); #1;
    rr[inst] = 1'b0;
    chk("release_ready", sr[inst] === 1'b1 && rv[inst] === 1'b0, {30'd0, sr[inst], rv[inst]}, 32'd2);
  endtask

  task automatic check_reset_vals(input string name);
    for (int i = 0; i < 2; i++) begin
      chk(name, sr[i] === 1'b1 && rv[i] === 1'b0 && res[i] === 32'd0 && asel[i] === 1'b0 &&
               ain0[i] === 32'd0 && ain1[i] === 32'd0,
          res[i] | ain0[i] | ain1[i] | {30'd0, rv[i], asel[i]}, 32'd0);
    end
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir [13] = '{
    '{2'b01, 32'd100,        32'd7},
    '{2'b11, 32'd100,        32'd7},
    '{2'b01, 32'hFFFF_FFFF,  32'd1},
    '{2'b00, 32'hFFFF_FFF9,  32'd2},
    '{2'b10, 32'hFFFF_FFF9,  32'd2},
    '{2'b00, 32'd7,          32'hFFFF_FFFE},
    '{2'b10, 32'd7,          32'hFFFF_FFFE},
    '{2'b01, 32'h1234_5678,  32'd0},
    '{2'b11, 32'h1234_5678,  32'd0},
    '{2'b00, 32'hFFFF_FFF9,  32'd0},
    '{2'b10, 32'hFFFF_FFF9,  32'd0},
    '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF},
    '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF}
  };

  initial begin
    int lat;
    bit saw;
    logic [1:0] o;
    logic [31:0] a, b;
    int inst, sel;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; opv[i] = 2'b00; av[i] = 32'd0; bv[i] = 32'd0; fl[i] = 1'b0; rr[i] = 1'b0;
    end
    #2;
    check_reset_vals("reset_state");
    #10 rst_n = 1'b1;

    // directed table on both variants
    for (int i = 0; i < 13; i++)
      for (int k = 0; k < 2; k++)
        run_op(k, dir[i].o, dir[i].a, dir[i].b, 0);

    // back-pressure in DONE with start_valid asserted
    run_op(0, 2'b01, 32'd1000, 32'd33, 5);
    run_op(1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5);

    // flush at ITER cycle 10
    @(posedge clk); #1;
    opv[0] = 2'b01; av[0] = 32'd100; bv[0] = 32'd7; sv[0] = 1'b1;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    fl[0] = 1'b1; rr[0] = 1'b1;
    @(posedge clk); #1;
    fl[0] = 1'b0; rr[0] = 1'b0;
    chk("flush_idle", sr[0] === 1'b1 && rv[0] === 1'b0, {30'd0, sr[0], rv[0]}, 32'd2);
    saw = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (rv[0] === 1'b1) saw = 1'b1;
    end
    chk("flush_no_result", !saw, 32'(saw), 32'd0);
    run_op(0, 2'b01, 32'd50, 32'd5, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      inst = $urandom_range(0, 1);
      o = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
      else if (sel == 3) b = $urandom_range(1, 9);
      run_op(inst, o, a, b, $urandom_range(0, 3));
    end

    // reset in the middle of ITER
    @(posedge clk); #1;
    opv[1] = 2'b00; av[1] = 32'hDEAD_BEEF; bv[1] = 32'd13; sv[1] = 1'b1;
    @(posedge clk); #1;
    sv[1] = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_iter");
    #1 rst_n = 1'b1;
    run_op(1, 2'b11, 32'd100, 32'd7, 0);

    chk("queue_drained", expq0.size() == 0 && expq1.size() == 0,
        32'(expq0.size() + expq1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
